// File: rtl/md_unit_ctrl_pkg.sv
// Shared opcodes, FSM state encoding and decode helpers for the multiply/divide unit.
// Build option: MD_MADD_EN adds the MADD/MADDU/MSUB/MSUBU accumulate operations.
package md_unit_ctrl_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdState_e;

  localparam logic [3:0] MD_OP_NONE  = 4'd0;
  localparam logic [3:0] MD_OP_MULT  = 4'd1;
  localparam logic [3:0] MD_OP_MULTU = 4'd2;
  localparam logic [3:0] MD_OP_DIV   = 4'd3;
  localparam logic [3:0] MD_OP_DIVU  = 4'd4;
  localparam logic [3:0] MD_OP_MTHI  = 4'd5;
  localparam logic [3:0] MD_OP_MTLO  = 4'd6;
  localparam logic [3:0] MD_OP_MFHI  = 4'd7;
  localparam logic [3:0] MD_OP_MFLO  = 4'd8;
  localparam logic [3:0] MD_OP_MADD  = 4'd9;
  localparam logic [3:0] MD_OP_MADDU = 4'd10;
  localparam logic [3:0] MD_OP_MSUB  = 4'd11;
  localparam logic [3:0] MD_OP_MSUBU = 4'd12;

  function automatic logic isDivOp(input logic [3:0] op);
    return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
  endfunction

  function automatic logic isSignedMul(input logic [3:0] op);
`ifdef MD_MADD_EN
    return (op == MD_OP_MULT) || (op == MD_OP_MADD) || (op == MD_OP_MSUB);
`else
    return (op == MD_OP_MULT);
`endif
  endfunction

  // Ops that occupy the unit for several cycles and therefore matter to hazard logic
  function automatic logic isLongOp(input logic [3:0] op);
`ifdef MD_MADD_EN
    return (op == MD_OP_MULT) || (op == MD_OP_MULTU) || isDivOp(op) ||
           (op == MD_OP_MADD) || (op == MD_OP_MADDU) ||
           (op == MD_OP_MSUB) || (op == MD_OP_MSUBU);
`else
    return (op == MD_OP_MULT) || (op == MD_OP_MULTU) || isDivOp(op);
`endif
  endfunction

`ifdef MD_MADD_EN
  function automatic logic isAccOp(input logic [3:0] op);
    return (op == MD_OP_MADD) || (op == MD_OP_MADDU) ||
           (op == MD_OP_MSUB) || (op == MD_OP_MSUBU);
  endfunction

  function automatic logic isSubOp(input logic [3:0] op);
    return (op == MD_OP_MSUB) || (op == MD_OP_MSUBU);
  endfunction
`endif

endpackage

// File: rtl/md_unit_ctrl_if.sv
// E-stage request / HI-LO result bundle between the pipeline and the md unit.
interface md_unit_ctrl_if;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        d_is_md;
  logic        busy;
  logic        stall_req;
  logic [31:0] md_rdata;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, md_op, rs_val, rt_val, d_is_md,
    input  busy, stall_req, md_rdata, hi, lo
  );

  modport slave (
    input  start, md_op, rs_val, rt_val, d_is_md,
    output busy, stall_req, md_rdata, hi, lo
  );
endinterface

// File: rtl/md_unit_ctrl_alu.sv
// Combinational 64-bit multiply/divide result generator with divide-by-zero flag.
// Build option: MD_MADD_EN adds the {hi,lo} accumulate/subtract path.
module md_alu
  import md_unit_ctrl_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rt,
`ifdef MD_MADD_EN
  input  logic [63:0] i_accPrev,
  input  logic [63:0] i_accTerm,
  input  logic        i_accSub,
  output logic [63:0] o_acc,
`endif
  output logic [63:0] o_result,
  output logic        o_divZero
);

  logic [63:0] w_mulA;
  logic [63:0] w_mulB;
  logic [63:0] w_product;
  logic        w_divSigned;
  logic        w_negA;
  logic        w_negB;
  logic [31:0] w_magA;
  logic [31:0] w_magB;
  logic [31:0] w_safeB;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic [31:0] w_divLo;
  logic [31:0] w_divHi;

  // Low 64 bits of a 64x64 product of extended operands equal the 32x32 product
  assign w_mulA    = isSignedMul(i_op) ? {{32{i_rs[31]}}, i_rs} : {32'd0, i_rs};
  assign w_mulB    = isSignedMul(i_op) ? {{32{i_rt[31]}}, i_rt} : {32'd0, i_rt};
  assign w_product = w_mulA * w_mulB;

  // Magnitude division keeps 0x80000000 / -1 well defined (quotient wraps to 0x80000000)
  assign w_divSigned = (i_op == MD_OP_DIV);
  assign w_negA      = w_divSigned & i_rs[31];
  assign w_negB      = w_divSigned & i_rt[31];
  assign w_magA      = w_negA ? (32'd0 - i_rs) : i_rs;
  assign w_magB      = w_negB ? (32'd0 - i_rt) : i_rt;
  assign w_safeB     = (w_magB == 32'd0) ? 32'd1 : w_magB;
  assign w_quot      = w_magA / w_safeB;
  assign w_rem       = w_magA % w_safeB;
  assign w_divLo     = (w_negA ^ w_negB) ? (32'd0 - w_quot) : w_quot;
  assign w_divHi     = w_negA ? (32'd0 - w_rem) : w_rem;

  assign o_result  = isDivOp(i_op) ? {w_divHi, w_divLo} : w_product;
  assign o_divZero = isDivOp(i_op) & (i_rt == 32'd0);

`ifdef MD_MADD_EN
  assign o_acc = i_accSub ? (i_accPrev - i_accTerm) : (i_accPrev + i_accTerm);
`endif

endmodule

// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencer owning HI/LO: fixed-latency busy countdown plus D-stage stall request.
// Build option: MD_MADD_EN enables MADD/MADDU/MSUB/MSUBU.
module md_unit_ctrl
  import md_unit_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic         clk,
  input  logic         reset,
  md_unit_ctrl_if.slave md
);

  localparam int CW = $clog2(DIV_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

  mdState_e    r_state;
  mdState_e    w_stateNext;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_countNext;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] w_hiNext;
  logic [31:0] w_loNext;
  logic [31:0] r_pendHi;
  logic [31:0] r_pendLo;
  logic [31:0] w_pendHiNext;
  logic [31:0] w_pendLoNext;
  logic        r_pendDivZero;
  logic        w_pendDivZeroNext;
  logic [63:0] w_aluResult;
  logic        w_aluDivZero;
  logic [63:0] w_commit;

`ifdef MD_MADD_EN
  logic        r_pendAcc;
  logic        r_pendSub;
  logic        w_pendAccNext;
  logic        w_pendSubNext;
  logic [63:0] w_acc;
`endif

  md_alu u_alu (
    .i_op      (md.md_op),
    .i_rs      (md.rs_val),
    .i_rt      (md.rt_val),
`ifdef MD_MADD_EN
    .i_accPrev ({r_hi, r_lo}),
    .i_accTerm ({r_pendHi, r_pendLo}),
    .i_accSub  (r_pendSub),
    .o_acc     (w_acc),
`endif
    .o_result  (w_aluResult),
    .o_divZero (w_aluDivZero)
  );

  // Accumulate ops fold the pending product into whatever HI/LO hold at commit time
`ifdef MD_MADD_EN
  assign w_commit = r_pendAcc ? w_acc : {r_pendHi, r_pendLo};
`else
  assign w_commit = {r_pendHi, r_pendLo};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_count       <= '0;
      r_hi          <= '0;
      r_lo          <= '0;
      r_pendHi      <= '0;
      r_pendLo      <= '0;
      r_pendDivZero <= 1'b0;
`ifdef MD_MADD_EN
      r_pendAcc     <= 1'b0;
      r_pendSub     <= 1'b0;
`endif
    end else begin
      r_state       <= w_stateNext;
      r_count       <= w_countNext;
      r_hi          <= w_hiNext;
      r_lo          <= w_loNext;
      r_pendHi      <= w_pendHiNext;
      r_pendLo      <= w_pendLoNext;
      r_pendDivZero <= w_pendDivZeroNext;
`ifdef MD_MADD_EN
      r_pendAcc     <= w_pendAccNext;
      r_pendSub     <= w_pendSubNext;
`endif
    end
  end

  always_comb begin
    w_stateNext       = r_state;
    w_countNext       = r_count;
    w_hiNext          = r_hi;
    w_loNext          = r_lo;
    w_pendHiNext      = r_pendHi;
    w_pendLoNext      = r_pendLo;
    w_pendDivZeroNext = r_pendDivZero;
`ifdef MD_MADD_EN
    w_pendAccNext     = r_pendAcc;
    w_pendSubNext     = r_pendSub;
`endif
    unique case (r_state)
      ST_IDLE: begin
        if (md.start) begin
          if (isLongOp(md.md_op)) begin
            w_stateNext       = ST_RUN;
            w_countNext       = isDivOp(md.md_op) ? DIV_LOAD : MULT_LOAD;
            w_pendHiNext      = w_aluResult[63:32];
            w_pendLoNext      = w_aluResult[31:0];
            w_pendDivZeroNext = w_aluDivZero;
`ifdef MD_MADD_EN
            w_pendAccNext     = isAccOp(md.md_op);
            w_pendSubNext     = isSubOp(md.md_op);
`endif
          end else if (md.md_op == MD_OP_MTHI) begin
            w_hiNext = md.rs_val;
          end else if (md.md_op == MD_OP_MTLO) begin
            w_loNext = md.rs_val;
          end
        end
      end
      ST_RUN: begin
        if (r_count == CW'(1)) begin
          w_stateNext = ST_IDLE;
          w_countNext = '0;
          if (!r_pendDivZero) begin
            w_hiNext = w_commit[63:32];
            w_loNext = w_commit[31:0];
          end
        end else begin
          w_countNext = r_count - CW'(1);
        end
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  assign md.busy      = (r_state == ST_RUN);
  assign md.stall_req = md.d_is_md & (md.busy | (md.start & isLongOp(md.md_op)));
  assign md.md_rdata  = (md.md_op == MD_OP_MFHI) ? r_hi :
                        (md.md_op == MD_OP_MFLO) ? r_lo : 32'd0;
  assign md.hi        = r_hi;
  assign md.lo        = r_lo;

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Scoreboard bench for md_unit_ctrl: stimulus queues expected HI/LO and read data, a monitor checks them.
// Build option: MD_MADD_EN switches the accumulate tests on.
module tb_md_unit_ctrl;
  import md_unit_ctrl_pkg::*;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
  } commitExp_t;

  typedef struct {
    string       name;
    logic [31:0] data;
  } readExp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic prevBusy = 1'b0;
  int checks = 0;
  int errors = 0;
  commitExp_t sbCommit[$];
  readExp_t   sbRead[$];

  md_unit_ctrl_if mdIf();

  md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (mdIf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One pipeline cycle of E-stage input, ending at the negedge where outputs are sampled
  task automatic applyStimulus(input logic st, input logic [3:0] op,
                               input logic [31:0] rs, input logic [31:0] rt);
    @(posedge clk);
    #1;
    mdIf.start  = st;
    mdIf.md_op  = op;
    mdIf.rs_val = rs;
    mdIf.rt_val = rt;
    @(negedge clk);
  endtask

  task automatic runLong(input string name, input logic [3:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, input int n, input logic dIsMd,
                         input logic [31:0] expHi, input logic [31:0] expLo);
    sbCommit.push_back('{name, expHi, expLo});
    mdIf.d_is_md = dIsMd;
    applyStimulus(1'b1, op, rs, rt);
    checkOutput({name, " stall c0"}, {31'd0, mdIf.stall_req}, {31'd0, dIsMd});
    for (int k = 1; k <= n; k++) begin
      applyStimulus(1'b0, MD_OP_NONE, 32'd0, 32'd0);
      checkOutput($sformatf("%s busy c%0d", name, k), {31'd0, mdIf.busy}, 32'd1);
      checkOutput($sformatf("%s stall c%0d", name, k), {31'd0, mdIf.stall_req}, {31'd0, dIsMd});
    end
    applyStimulus(1'b0, MD_OP_NONE, 32'd0, 32'd0);
    checkOutput({name, " busy done"}, {31'd0, mdIf.busy}, 32'd0);
    checkOutput({name, " stall done"}, {31'd0, mdIf.stall_req}, 32'd0);
    mdIf.d_is_md = 1'b0;
  endtask

  task automatic readOp(input string name, input logic [3:0] op, input logic [31:0] expData);
    sbRead.push_back('{name, expData});
    applyStimulus(1'b1, op, 32'd0, 32'd0);
  endtask

  // Monitor: a busy falling edge is a commit (or reset abort); an MFHI/MFLO issue is a read
  always @(negedge clk) begin
    if (prevBusy === 1'b1 && mdIf.busy === 1'b0) begin
      if (sbCommit.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected commit: hi 0x%08h lo 0x%08h required none", mdIf.hi, mdIf.lo);
      end else begin
        commitExp_t e;
        e = sbCommit.pop_front();
        checkOutput({e.name, " hi"}, mdIf.hi, e.hi);
        checkOutput({e.name, " lo"}, mdIf.lo, e.lo);
      end
    end
    if (mdIf.start === 1'b1 && (mdIf.md_op == MD_OP_MFHI || mdIf.md_op == MD_OP_MFLO)) begin
      if (sbRead.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected read: md_rdata 0x%08h required none", mdIf.md_rdata);
      end else begin
        readExp_t r;
        r = sbRead.pop_front();
        checkOutput({r.name, " md_rdata"}, mdIf.md_rdata, r.data);
      end
    end
    prevBusy = mdIf.busy;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    mdIf.start   = 1'b0;
    mdIf.md_op   = MD_OP_NONE;
    mdIf.rs_val  = 32'd0;
    mdIf.rt_val  = 32'd0;
    mdIf.d_is_md = 1'b1;
    reset        = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset busy", {31'd0, mdIf.busy}, 32'd0);
    checkOutput("reset stall", {31'd0, mdIf.stall_req}, 32'd0);
    checkOutput("reset hi", mdIf.hi, 32'd0);
    checkOutput("reset lo", mdIf.lo, 32'd0);
    mdIf.d_is_md = 1'b0;

    runLong("mult -2*3", MD_OP_MULT, 32'hFFFFFFFE, 32'd3, 5, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFA);
    runLong("divu 100/7", MD_OP_DIVU, 32'd100, 32'd7, 10, 1'b1, 32'd2, 32'd14);
    runLong("div -7/2", MD_OP_DIV, 32'hFFFFFFF9, 32'd2, 10, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD);
    runLong("div by 0", MD_OP_DIV, 32'd55, 32'd0, 10, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD);
    runLong("div ovf", MD_OP_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 1'b0, 32'd0, 32'h80000000);

    mdIf.d_is_md = 1'b1;
    applyStimulus(1'b1, MD_OP_MTHI, 32'h12345678, 32'd0);
    checkOutput("mthi stall", {31'd0, mdIf.stall_req}, 32'd0);
    checkOutput("mthi rdata", mdIf.md_rdata, 32'd0);
    readOp("mfhi", MD_OP_MFHI, 32'h12345678);
    checkOutput("mfhi busy", {31'd0, mdIf.busy}, 32'd0);
    mdIf.d_is_md = 1'b0;
    applyStimulus(1'b1, MD_OP_MTLO, 32'hCAFEBABE, 32'd0);
    readOp("mflo", MD_OP_MFLO, 32'hCAFEBABE);
    checkOutput("mflo busy", {31'd0, mdIf.busy}, 32'd0);

    applyStimulus(1'b1, 4'd13, 32'h55, 32'h66);
    applyStimulus(1'b1, 4'd15, 32'h77, 32'h88);
    applyStimulus(1'b1, MD_OP_NONE, 32'h99, 32'h11);
    checkOutput("unknown busy", {31'd0, mdIf.busy}, 32'd0);
    readOp("unknown mflo", MD_OP_MFLO, 32'hCAFEBABE);
    readOp("unknown mfhi", MD_OP_MFHI, 32'h12345678);

`ifdef MD_MADD_EN
    applyStimulus(1'b1, MD_OP_MTHI, 32'd0, 32'd0);
    applyStimulus(1'b1, MD_OP_MTLO, 32'd10, 32'd0);
    runLong("madd 3*4", MD_OP_MADD, 32'd3, 32'd4, 5, 1'b1, 32'd0, 32'd22);
    runLong("msubu 1*30", MD_OP_MSUBU, 32'd1, 32'd30, 5, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFF8);
`else
    mdIf.d_is_md = 1'b1;
    applyStimulus(1'b1, MD_OP_MADD, 32'd3, 32'd4);
    checkOutput("madd off stall", {31'd0, mdIf.stall_req}, 32'd0);
    applyStimulus(1'b0, MD_OP_NONE, 32'd0, 32'd0);
    checkOutput("madd off busy", {31'd0, mdIf.busy}, 32'd0);
    mdIf.d_is_md = 1'b0;
    readOp("madd off mflo", MD_OP_MFLO, 32'hCAFEBABE);
`endif

    // MULTU aborted by reset in cycle 3: state clears and no commit follows
    sbCommit.push_back('{"multu reset", 32'd0, 32'd0});
    applyStimulus(1'b1, MD_OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    applyStimulus(1'b0, MD_OP_NONE, 32'd0, 32'd0);
    applyStimulus(1'b0, MD_OP_NONE, 32'd0, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("multu c3 busy", {31'd0, mdIf.busy}, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("multu c4 busy", {31'd0, mdIf.busy}, 32'd0);
    repeat (10) applyStimulus(1'b0, MD_OP_NONE, 32'd0, 32'd0);
    checkOutput("post reset busy", {31'd0, mdIf.busy}, 32'd0);
    checkOutput("post reset hi", mdIf.hi, 32'd0);
    checkOutput("post reset lo", mdIf.lo, 32'd0);

    // Starts while RUN must be ignored
    sbCommit.push_back('{"mult 3*4 ign", 32'd0, 32'd12});
    applyStimulus(1'b1, MD_OP_MULT, 32'd3, 32'd4);
    applyStimulus(1'b0, MD_OP_NONE, 32'd0, 32'd0);
    applyStimulus(1'b1, MD_OP_MTHI, 32'h0000DEAD, 32'd0);
    readOp("mfhi in run", MD_OP_MFHI, 32'd0);
    applyStimulus(1'b1, MD_OP_MULT, 32'd5, 32'd5);
    applyStimulus(1'b0, MD_OP_NONE, 32'd0, 32'd0);
    applyStimulus(1'b0, MD_OP_NONE, 32'd0, 32'd0);
    readOp("mflo after ign", MD_OP_MFLO, 32'd12);
    checkOutput("ign busy", {31'd0, mdIf.busy}, 32'd0);
    applyStimulus(1'b0, MD_OP_NONE, 32'd0, 32'd0);
    checkOutput("ign hi", mdIf.hi, 32'd0);
    checkOutput("ign lo", mdIf.lo, 32'd12);

    for (int w = 0; w < 20 && (sbCommit.size() != 0 || sbRead.size() != 0); w++)
      @(negedge clk);
    if (sbCommit.size() != 0 || sbRead.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d commits and %0d reads outstanding, required 0",
               sbCommit.size(), sbRead.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_unit_ctrl.md
Name: md_unit_ctrl

Overview:
- Sequencer and owner of the multiply/divide resource and the HI/LO registers in the 5-stage MIPS pipeline.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO operations from the E stage.
- Models fixed multi-cycle latency with a busy countdown.
- Raises a stall request to the hazard logic when a D-stage md instruction would collide with an operation still in flight.

Parameters:
- MULT_CYCLES, 5, busy cycles after a MULT/MULTU start (>=1)
- DIV_CYCLES, 10, busy cycles after a DIV/DIVU start (>=1, >=MULT_CYCLES)

Ports:
- clk  input  1  pipeline clock
- reset  input  1  synchronous active-high reset
- start  input  1  E-stage md operation valid this cycle
- md_op  input  4  operation code (package constants)
- rs_val  input  32  forwarded GPR[rs] in E
- rt_val  input  32  forwarded GPR[rt] in E
- d_is_md  input  1  D-stage instruction is any md operation
- busy  output  1  multi-cycle operation in progress
- stall_req  output  1  stall D stage
- md_rdata  output  32  HI (MFHI) or LO (MFLO) read data for E result mux
- hi  output  32  architectural HI
- lo  output  32  architectural LO

Behaviour:
- Single clock domain, synchronous active-high reset. Reset forces the following:
  - state=IDLE, counter=0, hi=0, lo=0, pending regs=0.
  - busy=0, stall_req=0.
- Reset mid-operation discards the pending result; HI/LO read 0 the next cycle.
- States:
  - IDLE: accepts start.
  - RUN: counting down.
- IDLE, start & (MULT|MULTU|DIV|DIVU):
  - Compute the result from rs_val/rt_val in that cycle into pending_hi/pending_lo.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN.
- RUN: counter decrements each cycle. When counter==1, commit pending to hi/lo at that edge and go to IDLE.
- Timing: start in cycle 0 gives busy=1 in cycles 1..N, busy=0 and new HI/LO visible in cycle N+1.
- Arithmetic:
  - MULT: signed 32x32 -> 64; {hi,lo}=product.
  - MULTU: same, unsigned.
  - DIV: signed; lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - DIVU: unsigned.
- Divide by zero: state still enters RUN for DIV_CYCLES, but HI/LO stay unchanged at commit.
- Signed DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- MTHI/MTLO (start in IDLE): write rs_val to hi/lo at the next edge; busy stays 0.
- MFHI/MFLO: md_rdata is combinational from the current hi/lo. md_rdata=0 for all other ops.
- Any start while in RUN is ignored. The hazard unit must prevent this via stall_req; the bench checks that HI/LO are unaffected.
- stall_req = d_is_md & (busy | (start & md_op is MULT/MULTU/DIV/DIVU)). Combinational, no registered delay.
- stall_req is 0 when d_is_md=0, even while busy.
- Unknown md_op with start: no effect.
- busy = (state==RUN).

Optional Feature:
- MD_MADD_EN defined:
  - Adds op codes MADD/MADDU/MSUB/MSUBU.
  - {hi,lo} += or -= (signed or unsigned) rs*rt, computed at commit from the then-current {hi,lo}.
  - Latency MULT_CYCLES; these ops count as md ops for stall_req.
- MD_MADD_EN undefined: those codes decode as unknown (no effect); accumulate logic is absent.

Decomposition:
- Shared package/macro header (alongside the existing opcode macros):
  - MD_OP_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8, MADD=9, MADDU=10, MSUB=11, MSUBU=12.
  - State encodings IDLE/RUN.
- One natural sub-module: md_alu, a combinational 64-bit multiply/divide result generator, including divide-by-zero flag and optional accumulate. The controller holds only the FSM, counter, pending regs and HI/LO.

Test Plan:
- Reset then MULT rs=0xFFFFFFFE (-2), rt=3 at cycle 0:
  - busy=1 in cycles 1..5.
  - Cycle 6: hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0.
- DIVU rs=100, rt=7, with d_is_md=1 held:
  - stall_req=1 in cycles 0..10.
  - Cycle 11: lo=14, hi=2, stall_req=0.
- DIV rs=-7 (0xFFFFFFF9), rt=2: after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIV by rt=0: HI/LO unchanged after its 10 busy cycles.
- MTHI rs=0x12345678 then MFHI next cycle:
  - busy never asserts.
  - md_rdata=0x12345678.
  - Then MTLO 0xCAFEBABE; MFLO returns 0xCAFEBABE.
- MULTU 0xFFFFFFFF*0xFFFFFFFF, reset asserted at cycle 3:
  - Cycle 4: busy=0, hi=lo=0.
  - No later commit.
  - A start pulsed during RUN in a separate run leaves HI/LO equal to the first result only.
- MD_MADD_EN build: hi=0, lo=10, MADD rs=3 rt=4 -> after 5 cycles lo=22. MSUBU rs=1 rt=30 -> hi=0xFFFFFFFF, lo=0xFFFFFFF8.
